interrupt_nested: RTL and testbench
===================================

# interrupt_nested

Parametrised multi-level, nesting interrupt controller for the PulseRain MCU core: the successor to the fixed 7-source, 2-level controller. It captures level- or edge-type requests from `NUM_OF_INT` sources and arbitrates them over `NUM_OF_LEVELS` programmable priority levels. It tracks nested ISRs on an internal level stack and issues a one-cycle `int_gen` strobe with a computed vector address to the CPU fetch unit.

## Interface
- `NUM_OF_INT`, 8: number of sources; range 2..32.
- `NUM_OF_LEVELS`, 4: number of priority levels; range 2..8; level `NUM_OF_LEVELS-1` is highest.
- `VECTOR_BASE`, 8'h03: vector address of source 0.
- `VECTOR_STRIDE`, 8: address step between consecutive sources.
- `HOLDOFF_CYCLES`, 3: idle cycles after each dispatch; range 1..15.
- Derived: `LW = max(1, $clog2(NUM_OF_LEVELS))`.

Ports:
- `clk` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `global_int_enable` in 1: master enable.
- `ret_int` in 1: one-cycle pulse when the CPU executes RETI.
- `int_enable_mask` in `NUM_OF_INT`: per-source enable.
- `int_level1_pulse0` in `NUM_OF_INT`: 1 = level source, 0 = rising-edge source.
- `int_priority` in `NUM_OF_INT*LW`: level of source i is in bits `[i*LW +: LW]`.
- `int_pins` in `NUM_OF_INT`: raw requests, already synchronous to `clk`.
- `sw_int_set` in `NUM_OF_INT`: software trigger, present only with the macro defined.
- `int_gen` out 1: dispatch strobe.
- `int_addr` out 8: vector address; valid while `int_gen` is high and held afterwards.
- `int_pending` out `NUM_OF_INT`: pending register.
- `nest_depth` out `$clog2(NUM_OF_LEVELS+1)`: number of active ISRs.
- `active_level` out `LW`: level on top of the stack; 0 when the stack is empty.

## Operation
- **Pending capture**
  - Level source: `int_pending[i]` follows `int_pins[i]` registered.
  - Edge source: set on `int_pins & ~int_pins_d1`. Cleared on the cycle `int_gen` dispatches source i.
  - If set and clear coincide, set wins.
- **Candidates**: `int_pending & int_enable_mask`, filtered to levels strictly greater than `active_level`. When `nest_depth == 0`, every level qualifies.
- **Arbitration**: the highest level wins. On a level tie, the lowest index wins.
- **Stack**: depth `NUM_OF_LEVELS`, holding level values.
  - Dispatch pushes the winner's level.
  - `ret_int` pops. `ret_int` with an empty stack is ignored.
  - `ret_int` in the same cycle as a dispatch: pop first, then push; `nest_depth` is unchanged.
  - Strict-greater preemption bounds the depth, so overflow is impossible. The stack still asserts no push when full.
- **Vector address**: `int_addr = VECTOR_BASE + idx*VECTOR_STRIDE`, computed modulo 256 (8-bit wrap, no saturation).
- **FSM states**: S_IDLE, S_ARB, S_DISPATCH, S_HOLDOFF.
  - S_IDLE → S_ARB when `global_int_enable` is high and any candidate exists; otherwise stays in S_IDLE.
  - S_ARB: registers the winner index and level → S_DISPATCH.
  - S_DISPATCH: if `global_int_enable` is still high and the latched winner is still pending and enabled, assert `int_gen`, load `int_addr`, push the stack, load the holdoff counter → S_HOLDOFF. Otherwise abort to S_IDLE with no strobe and pending retained.
  - S_HOLDOFF: counter decrements; at 0 → S_IDLE.
- **Global enable**: `global_int_enable` low never clears pending bits or the stack.

## Timing
- **Reset values**: `int_gen` 0, `int_addr` 0, `int_pending` 0, `nest_depth` 0, `active_level` 0, FSM S_IDLE, stack empty.
- **Reset mid-operation**: all of the above apply immediately (asynchronous); no `int_gen` is issued for a request in flight.
- **Pin to pending**: pin edge sampled at edge E → `int_pending` bit visible after E.
- **Pending to strobe**: `int_gen` goes high 2 cycles after `int_pending` becomes visible (IDLE, ARB, then DISPATCH register).
- **Strobe width**: `int_gen` is exactly 1 cycle wide.
- **Dispatch rate**: minimum spacing between strobes is `3 + HOLDOFF_CYCLES` cycles.
- **Outputs after events**: `nest_depth` and `active_level` update the cycle after the push or pop.
- **`ret_int` vs. strobe timing**: a `ret_int` in the cycle before `int_gen` affects candidate filtering only from the next arbitration onward.

## Configuration
- `INTERRUPT_SW_TRIGGER_EN` defined:
  - `sw_int_set` exists.
  - A 1 on bit i sets `int_pending[i]` for both source types.
  - For a level source, the set lasts until the next dispatch of that source.
- `INTERRUPT_SW_TRIGGER_EN` undefined:
  - The port and its logic are absent.
  - Pending comes only from `int_pins`.

## Test plan
- **Single edge dispatch**: NUM_OF_INT=8, source 3 edge-type, level 1, enabled; pulse `int_pins[3]` → `int_gen` one cycle, `int_addr`=8'h1B, `nest_depth`=1, `int_pending[3]` cleared.
- **Tie-break**: sources 2 and 5 at level 2 pending together → source 2 dispatched (`int_addr`=8'h13). After `ret_int` and holdoff, source 5 is dispatched (8'h2B).
- **Nesting**:
  - Source 1 runs at level 1.
  - Source 6 arrives at level 3 → preempts, `nest_depth`=2, `active_level`=3.
  - Source 4 arrives at level 3 → not dispatched until `ret_int`.
- **Enable abort and empty RETI**: drop `global_int_enable` during S_ARB → no `int_gen`, pending retained; re-enable → dispatch. `ret_int` with an empty stack → `nest_depth` stays 0.
- **Address wrap**: VECTOR_BASE=8'hF0, VECTOR_STRIDE=8, source 3 → `int_addr`=8'h08.
- **Async reset**: assert `reset_n` low while in S_DISPATCH with depth 2 → all outputs 0 immediately; no strobe after release until a new request.

Source files
------------

// File: rtl/interrupt_nested.sv
// interrupt_nested: nesting priority interrupt controller with level stack and vectored int_gen strobe.
// Defining INTERRUPT_SW_TRIGGER_EN adds the sw_int_set software trigger port.
module interrupt_nested #(
    parameter int         NUM_OF_INT     = 8,
    parameter int         NUM_OF_LEVELS  = 4,
    parameter logic [7:0] VECTOR_BASE    = 8'h03,
    parameter int         VECTOR_STRIDE  = 8,
    parameter int         HOLDOFF_CYCLES = 3,
    localparam int        LW = (NUM_OF_LEVELS > 2) ? $clog2(NUM_OF_LEVELS) : 1,
    localparam int        DW = $clog2(NUM_OF_LEVELS + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     global_int_enable,
    input  logic                     ret_int,
    input  logic [NUM_OF_INT-1:0]    int_enable_mask,
    input  logic [NUM_OF_INT-1:0]    int_level1_pulse0,
    input  logic [NUM_OF_INT*LW-1:0] int_priority,
    input  logic [NUM_OF_INT-1:0]    int_pins,
`ifdef INTERRUPT_SW_TRIGGER_EN
    input  logic [NUM_OF_INT-1:0]    sw_int_set,
`endif
    output logic                     int_gen,
    output logic [7:0]               int_addr,
    output logic [NUM_OF_INT-1:0]    int_pending,
    output logic [DW-1:0]            nest_depth,
    output logic [LW-1:0]            active_level
);
    localparam int IW = (NUM_OF_INT > 1) ? $clog2(NUM_OF_INT) : 1;
    typedef enum logic [1:0] {S_IDLE, S_ARB, S_DISPATCH, S_HOLDOFF} state_t;
    state_t                state, state_nxt;
    logic [NUM_OF_INT-1:0] pins_d1, dispatched, pend_nxt;
    logic [IW-1:0]         win_idx, arb_idx;
    logic [LW-1:0]         win_lvl, arb_lvl, top_lvl;
    logic [LW-1:0]         stack [NUM_OF_LEVELS];
    logic [3:0]            hold_cnt;
    logic [7:0]            addr_q, addr_calc;
    logic                  arb_found, pop;

    assign int_gen      = state == S_DISPATCH && global_int_enable && int_pending[win_idx] && int_enable_mask[win_idx];
    assign dispatched   = int_gen ? NUM_OF_INT'(1) << win_idx : '0;
    assign addr_calc    = VECTOR_BASE + 8'(32'(win_idx) * VECTOR_STRIDE);
    assign int_addr     = int_gen ? addr_calc : addr_q;
    assign pop          = ret_int && nest_depth != '0;
    assign top_lvl      = stack[LW'(nest_depth - DW'(1))];
    assign active_level = (nest_depth == '0) ? '0 : top_lvl;

`ifdef INTERRUPT_SW_TRIGGER_EN
    // a software set on a level source is held until that source is dispatched
    logic [NUM_OF_INT-1:0] sw_hold, sw_nxt;
    assign sw_nxt   = sw_int_set | (sw_hold & ~dispatched);
    assign pend_nxt = (int_level1_pulse0 & (int_pins | sw_nxt)) |
                      (~int_level1_pulse0 & ((int_pins & ~pins_d1) | sw_int_set | (int_pending & ~dispatched)));
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sw_hold <= '0;
        else sw_hold <= sw_nxt;
    end
`else
    assign pend_nxt = (int_level1_pulse0 & int_pins) |
                      (~int_level1_pulse0 & ((int_pins & ~pins_d1) | (int_pending & ~dispatched)));
`endif

    // strictly-greater test keeps the lowest index on a level tie
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_lvl   = '0;
        for (int i = 0; i < NUM_OF_INT; i++) begin
            if (int_pending[i] && int_enable_mask[i] &&
                (nest_depth == '0 || int_priority[i*LW +: LW] > active_level) &&
                (!arb_found || int_priority[i*LW +: LW] > arb_lvl)) begin
                arb_found = 1'b1;
                arb_idx   = IW'(i);
                arb_lvl   = int_priority[i*LW +: LW];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     state_nxt = (global_int_enable && arb_found) ? S_ARB : S_IDLE;
            S_ARB:      state_nxt = arb_found ? S_DISPATCH : S_IDLE;
            S_DISPATCH: state_nxt = int_gen ? S_HOLDOFF : S_IDLE;
            default:    state_nxt = (hold_cnt <= 4'd1) ? S_IDLE : S_HOLDOFF;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            pins_d1     <= '0;
            int_pending <= '0;
            win_idx     <= '0;
            win_lvl     <= '0;
            hold_cnt    <= '0;
            addr_q      <= '0;
        end else begin
            state       <= state_nxt;
            pins_d1     <= int_pins;
            int_pending <= pend_nxt;
            if (state == S_ARB) begin
                win_idx <= arb_idx;
                win_lvl <= arb_lvl;
            end
            if (int_gen) begin
                addr_q   <= addr_calc;
                hold_cnt <= 4'(HOLDOFF_CYCLES);
            end else if (state == S_HOLDOFF) begin
                hold_cnt <= hold_cnt - 4'd1;
            end
        end
    end

    // simultaneous RETI and dispatch replace the top entry in place
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nest_depth <= '0;
            for (int i = 0; i < NUM_OF_LEVELS; i++) stack[i] <= '0;
        end else if (int_gen && pop) begin
            stack[LW'(nest_depth - DW'(1))] <= win_lvl;
        end else if (int_gen && nest_depth < DW'(NUM_OF_LEVELS)) begin
            stack[LW'(nest_depth)] <= win_lvl;
            nest_depth <= nest_depth + DW'(1);
        end else if (pop) begin
            nest_depth <= nest_depth - DW'(1);
        end
    end

    assert property (@(posedge clk) disable iff (!reset_n)
        !(int_gen && !pop && nest_depth == DW'(NUM_OF_LEVELS)));
endmodule

// File: tb/tb_interrupt_nested.sv
// tb_interrupt_nested: directed and randomized checks of interrupt_nested against a dispatch-schedule model.
module tb_interrupt_nested;
    localparam int N  = 8;
    localparam int LW = 2;
    localparam int DW = 3;
    localparam int H  = 3;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            global_int_enable = 1'b0;
    logic            ret_int = 1'b0;
    logic [N-1:0]    int_enable_mask = '0;
    logic [N-1:0]    int_level1_pulse0 = '0;
    logic [N-1:0]    int_pins = '0;
    logic [N*LW-1:0] int_priority = '0;
    logic            int_gen, int_gen_w;
    logic [7:0]      int_addr, int_addr_w;
    logic [N-1:0]    int_pending, int_pending_w;
    logic [DW-1:0]   nest_depth, nest_depth_w;
    logic [LW-1:0]   active_level, active_level_w;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] m_pend, m_d1;
    int m_stack[$];
    int cyc, arb_at, disp_at, free_at, m_win, m_wlvl;
    logic [7:0] m_addr, m_addr_w;
    bit last_gen;
    logic [7:0] last_addr;

    always #5 clk = ~clk;

    interrupt_nested dut (
        .clk(clk), .reset_n(reset_n), .global_int_enable(global_int_enable), .ret_int(ret_int),
        .int_enable_mask(int_enable_mask), .int_level1_pulse0(int_level1_pulse0),
        .int_priority(int_priority), .int_pins(int_pins),
`ifdef INTERRUPT_SW_TRIGGER_EN
        .sw_int_set('0),
`endif
        .int_gen(int_gen), .int_addr(int_addr), .int_pending(int_pending),
        .nest_depth(nest_depth), .active_level(active_level)
    );

    interrupt_nested #(.VECTOR_BASE(8'hF0)) dut_w (
        .clk(clk), .reset_n(reset_n), .global_int_enable(global_int_enable), .ret_int(ret_int),
        .int_enable_mask(int_enable_mask), .int_level1_pulse0(int_level1_pulse0),
        .int_priority(int_priority), .int_pins(int_pins),
`ifdef INTERRUPT_SW_TRIGGER_EN
        .sw_int_set('0),
`endif
        .int_gen(int_gen_w), .int_addr(int_addr_w), .int_pending(int_pending_w),
        .nest_depth(nest_depth_w), .active_level(active_level_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lvl_of(input int i);
        return int'(int_priority[i*LW +: LW]);
    endfunction

    function automatic int top_lvl();
        return (m_stack.size() == 0) ? 0 : m_stack[$];
    endfunction

    function automatic logic [7:0] vaddr(input int base, input int idx);
        return 8'((base + idx * 8) % 256);
    endfunction

    // highest enabled pending level above the running ISR; lowest index on ties
    function automatic int best();
        int b = -1;
        for (int i = 0; i < N; i++)
            if (m_pend[i] && int_enable_mask[i] && (m_stack.size() == 0 || lvl_of(i) > top_lvl()))
                if (b < 0 || lvl_of(i) > lvl_of(b)) b = i;
        return b;
    endfunction

    function automatic bit exp_gen();
        return (cyc == disp_at) && global_int_enable && m_pend[m_win] && int_enable_mask[m_win];
    endfunction

    task automatic model_reset();
        m_pend = '0;
        m_d1 = '0;
        m_stack.delete();
        arb_at = -1;
        disp_at = -1;
        free_at = 0;
        m_win = 0;
        m_wlvl = 0;
        m_addr = '0;
        m_addr_w = '0;
    endtask

    task automatic model_step();
        bit g;
        int b;
        g = exp_gen();
        b = best();
        if (ret_int && m_stack.size() > 0) void'(m_stack.pop_back());
        if (g) begin
            m_stack.push_back(m_wlvl);
            m_addr = vaddr(8'h03, m_win);
            m_addr_w = vaddr(8'hF0, m_win);
        end
        if (cyc == disp_at) free_at = g ? cyc + 1 + H : cyc + 1;
        if (cyc == arb_at) begin
            if (b < 0) free_at = cyc + 1;
            else begin
                m_win = b;
                m_wlvl = lvl_of(b);
                disp_at = cyc + 1;
            end
        end else if (cyc >= free_at && global_int_enable && b >= 0) begin
            arb_at = cyc + 1;
            free_at = 1 << 30;
        end
        for (int i = 0; i < N; i++)
            m_pend[i] = int_level1_pulse0[i] ? int_pins[i]
                      : ((int_pins[i] & ~m_d1[i]) | (m_pend[i] & !(g && m_win == i)));
        m_d1 = int_pins;
        cyc++;
    endtask

    task automatic compare_all();
        bit eg;
        eg = exp_gen();
        check("int_gen", int_gen, eg);
        check("int_addr", int_addr, eg ? vaddr(8'h03, m_win) : m_addr);
        check("int_pending", int_pending, m_pend);
        check("nest_depth", nest_depth, m_stack.size());
        check("active_level", active_level, top_lvl());
        check("wrap_gen", int_gen_w, eg);
        check("wrap_addr", int_addr_w, eg ? vaddr(8'hF0, m_win) : m_addr_w);
        check("wrap_pending", int_pending_w, m_pend);
        check("wrap_depth", nest_depth_w, m_stack.size());
        check("wrap_level", active_level_w, top_lvl());
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        last_gen = int_gen;
        last_addr = int_addr;
        @(posedge clk);
        if (reset_n) model_step();
        else model_reset();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse(input int i);
        int_pins[i] = 1'b1;
        step();
        int_pins[i] = 1'b0;
    endtask

    task automatic retire();
        ret_int = 1'b1;
        step();
        ret_int = 1'b0;
    endtask

    task automatic set_prio(input int i, input int l);
        int_priority[i*LW +: LW] = LW'(l);
    endtask

    task automatic wait_gen(input string tag, input logic [7:0] exp_addr);
        int k = 0;
        do begin
            step();
            k++;
        end while (!last_gen && k < 40);
        check({tag, "_strobe"}, last_gen, 1);
        check({tag, "_addr"}, last_addr, exp_addr);
    endtask

    initial begin
        int k, g;
        cyc = 0;
        model_reset();
        step();
        check("rst_gen", int_gen, 0);
        check("rst_addr", int_addr, 0);
        check("rst_pend", int_pending, 0);
        check("rst_depth", nest_depth, 0);
        check("rst_level", active_level, 0);
        reset_n = 1'b1;
        global_int_enable = 1'b1;
        int_enable_mask = '1;
        step();

        set_prio(3, 1);
        pulse(3);
        wait_gen("edge3", 8'h1B);
        check("edge3_depth", nest_depth, 1);
        check("edge3_clear", int_pending[3], 0);
        retire();
        idle(6);

        set_prio(2, 2);
        set_prio(5, 2);
        int_pins[2] = 1'b1;
        int_pins[5] = 1'b1;
        step();
        int_pins = '0;
        wait_gen("tie_first", 8'h13);
        retire();
        wait_gen("tie_second", 8'h2B);
        retire();
        idle(6);

        set_prio(1, 1);
        set_prio(6, 3);
        set_prio(4, 3);
        pulse(1);
        wait_gen("nest_src1", 8'h0B);
        pulse(6);
        wait_gen("nest_src6", 8'h33);
        check("nest_depth2", nest_depth, 2);
        check("nest_level3", active_level, 3);
        pulse(4);
        idle(20);
        check("nest_src4_held", int_pending[4], 1);
        retire();
        wait_gen("nest_src4", 8'h23);
        check("nest_src4_depth", nest_depth, 2);
        retire();
        retire();
        idle(6);

        set_prio(0, 0);
        pulse(0);
        step();
        global_int_enable = 1'b0;
        g = 0;
        repeat (6) begin
            step();
            g += int'(last_gen);
        end
        check("abort_no_strobe", g, 0);
        check("abort_pend", int_pending[0], 1);
        global_int_enable = 1'b1;
        wait_gen("abort_redo", 8'h03);
        retire();
        retire();
        check("empty_reti", nest_depth, 0);
        idle(6);

        set_prio(2, 2);
        pulse(1);
        wait_gen("rst_src1", 8'h0B);
        pulse(2);
        wait_gen("rst_src2", 8'h13);
        check("rst_pre_depth", nest_depth, 2);
        pulse(6);
        k = 0;
        while (cyc != disp_at && k < 40) begin
            step();
            k++;
        end
        check("rst_reach_dispatch", k < 40, 1);
        reset_n = 1'b0;
        #1;
        check("async_gen", int_gen, 0);
        check("async_addr", int_addr, 0);
        check("async_pend", int_pending, 0);
        check("async_depth", nest_depth, 0);
        check("async_level", active_level, 0);
        model_reset();
        idle(2);
        reset_n = 1'b1;
        g = 0;
        repeat (10) begin
            step();
            g += int'(last_gen);
        end
        check("rst_no_strobe", g, 0);

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                int_enable_mask = N'($urandom | $urandom);
                int_level1_pulse0 = N'($urandom);
                int_priority = (N*LW)'($urandom);
            end
            int_pins = N'($urandom & $urandom & $urandom);
            ret_int = ($urandom_range(0, 7) == 0);
            global_int_enable = ($urandom_range(0, 15) != 0);
            step();
        end
        ret_int = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
